// File: rtl/igbt_flt_mon_pkg.sv
// Shared types and constants for the IGBT driver fault monitor.
// Channel indices follow the H-bridge switch numbering K_1..K_4.
package igbt_pkg;

  localparam int NCH   = 4;
  localparam int CH_K1 = 0;
  localparam int CH_K2 = 1;
  localparam int CH_K3 = 2;
  localparam int CH_K4 = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PULSE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Width of a counter that must hold 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/igbt_flt_mon_filt.sv
// One driver fault line: 2-FF synchroniser followed by a consecutive-sample glitch filter.
// o_flt_lvl is the filtered fault level (1 = fault); o_flt_nxt is the level being loaded this cycle.
module flt_filt
  import igbt_pkg::*;
#(
  parameter int FILT_CYC = 20
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_flt_n,
  output logic o_flt_lvl,
  output logic o_flt_nxt
);

  localparam int CW = cnt_w(FILT_CYC);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_lvl;
  logic [CW-1:0] r_cnt;
  logic          w_smp;
  logic          w_flip;

  assign w_smp  = ~r_sync2;
  assign w_flip = (w_smp != r_lvl) && (r_cnt == CW'(FILT_CYC - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_lvl   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_flt_n;
      r_sync2 <= r_sync1;
      if (w_smp == r_lvl) begin
        r_cnt <= '0;
      end else if (w_flip) begin
        r_lvl <= w_smp;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Exposing the incoming level lets the latch set on the same edge the filter flips.
  assign o_flt_lvl = r_lvl;
  assign o_flt_nxt = w_flip ? w_smp : r_lvl;

endmodule

// File: rtl/igbt_flt_mon.sv
// Driver fault front end: filters the four fault lines, latches per-switch faults and runs
// the chkflt -> igbt_rst pulse/wait/check retry loop ending in a one-clock chkflt_over.
module igbt_flt_mon
  import igbt_pkg::*;
#(
  parameter int FILT_CYC      = 20,
  parameter int RST_PULSE_CYC = 500,
  parameter int RST_WAIT_CYC  = 1000,
  parameter int RETRY_MAX     = 3
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [NCH-1:0] drv_flt_n,
  input  logic           chkflt,
  output logic           fault1,
  output logic           fault2,
  output logic           fault3,
  output logic           fault4,
  output logic           fault,
  output logic [NCH-1:0] igbt_rst,
  output logic           chkflt_over,
  output state_t         dbg_state
);

  localparam int CMAX = (RST_PULSE_CYC > RST_WAIT_CYC) ? RST_PULSE_CYC : RST_WAIT_CYC;
  localparam int CW   = cnt_w(CMAX);
  localparam int RW   = $clog2(RETRY_MAX + 1);

  logic [NCH-1:0] w_flt_lvl;
  logic [NCH-1:0] w_flt_nxt;
  logic [NCH-1:0] r_latch;
  logic [NCH-1:0] w_latch_nxt;
  logic [NCH-1:0] w_clr;
  logic [NCH-1:0] w_remaining;
  logic           r_chk;
  logic           r_chk_prev;
  logic           w_chk_rise;
  state_t         r_state;
  state_t         w_state_nxt;
  logic [CW-1:0]  r_cnt;
  logic [CW-1:0]  w_cnt_nxt;
  logic [RW-1:0]  r_retry;
  logic [RW-1:0]  w_retry_nxt;
  logic [NCH-1:0] r_mask;
  logic [NCH-1:0] w_mask_nxt;
  logic [NCH-1:0] r_igbt_rst;
  logic           r_over;
  logic           r_fault;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    flt_filt #(.FILT_CYC(FILT_CYC)) u_filt (
      .clk       (clk),
      .rstn      (rstn),
      .i_flt_n   (drv_flt_n[g]),
      .o_flt_lvl (w_flt_lvl[g]),
      .o_flt_nxt (w_flt_nxt[g])
    );
  end

  // Request/ack: a rising edge on chkflt seen in IDLE is the request; chkflt_over is a
  // single-clock acknowledge when the sequence ends. Edges while busy are dropped, not queued.
  assign w_chk_rise  = r_chk & ~r_chk_prev;
  assign w_clr       = (r_state == ST_CHECK) ? ~w_flt_lvl : '0;
  assign w_remaining = r_latch & w_flt_lvl & r_mask;
  assign w_latch_nxt = (r_latch & ~w_clr) | w_flt_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_retry_nxt = r_retry;
    w_mask_nxt  = r_mask;
    case (r_state)
      ST_IDLE: begin
        if (w_chk_rise) begin
          if (r_latch == '0) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_mask_nxt  = r_latch;
            w_retry_nxt = RW'(1);
            w_cnt_nxt   = '0;
            w_state_nxt = ST_PULSE;
          end
        end
      end
      ST_PULSE: begin
        if (r_cnt == CW'(RST_PULSE_CYC - 1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_WAIT;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_WAIT: begin
        if (r_cnt == CW'(RST_WAIT_CYC - 1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_CHECK;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_CHECK: begin
        // Only switches still failing from the original mask are retried.
        if ((w_remaining == '0) || (r_retry == RW'(RETRY_MAX))) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_mask_nxt  = w_remaining;
          w_retry_nxt = r_retry + 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_PULSE;
        end
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_chk      <= 1'b0;
      r_chk_prev <= 1'b0;
      r_latch    <= '0;
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_retry    <= '0;
      r_mask     <= '0;
      r_igbt_rst <= '0;
      r_over     <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_chk      <= chkflt;
      r_chk_prev <= r_chk;
      r_latch    <= w_latch_nxt;
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_retry    <= w_retry_nxt;
      r_mask     <= w_mask_nxt;
      r_igbt_rst <= (w_state_nxt == ST_PULSE) ? w_mask_nxt : '0;
      r_over     <= (w_state_nxt == ST_DONE);
      r_fault    <= |w_latch_nxt;
    end
  end

  assign fault1      = r_latch[CH_K1];
  assign fault2      = r_latch[CH_K2];
  assign fault3      = r_latch[CH_K3];
  assign fault4      = r_latch[CH_K4];
  assign fault       = r_fault;
  assign igbt_rst    = r_igbt_rst;
  assign chkflt_over = r_over;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_igbt_flt_mon.sv
// Directed bench for igbt_flt_mon: filter latency, latching, clear sequence, retries, reset.
module tb_igbt_flt_mon;
  import igbt_pkg::*;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] drv_flt_n;
  logic       chkflt;
  logic       fault1, fault2, fault3, fault4, fault;
  logic [3:0] igbt_rst;
  logic       chkflt_over;
  state_t     dbg_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  igbt_flt_mon dut (
    .clk         (clk),
    .rstn        (rstn),
    .drv_flt_n   (drv_flt_n),
    .chkflt      (chkflt),
    .fault1      (fault1),
    .fault2      (fault2),
    .fault3      (fault3),
    .fault4      (fault4),
    .fault       (fault),
    .igbt_rst    (igbt_rst),
    .chkflt_over (chkflt_over),
    .dbg_state   (dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  // Watches one clear sequence until chkflt_over, then 200 quiet cycles.
  task automatic run_seq(input int glitch_at, input logic [3:0] exp_mask,
                         output int pulses, output int minw, output int maxw,
                         output int overs, output int bad);
    int w;
    pulses = 0; minw = 1000000; maxw = 0; overs = 0; bad = 0; w = 0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (i == glitch_at) chkflt = 1'b0;
      if (i == glitch_at + 10) chkflt = 1'b1;
      if (igbt_rst !== 4'b0000) begin
        if (igbt_rst !== exp_mask) bad++;
        w++;
      end else if (w != 0) begin
        pulses++;
        if (w < minw) minw = w;
        if (w > maxw) maxw = w;
        w = 0;
      end
      if (chkflt_over === 1'b1) begin
        overs++;
        break;
      end
    end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (chkflt_over !== 1'b0) overs++;
      if (igbt_rst !== 4'b0000) bad++;
    end
  endtask

  initial begin
    int n, nz, pulses, minw, maxw, overs, bad;
    rstn = 1'b0; drv_flt_n = 4'hF; chkflt = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_fault", fault, 0);
    chk("rst_fault_vec", {fault4, fault3, fault2, fault1}, 0);
    chk("rst_igbt_rst", igbt_rst, 0);
    chk("rst_over", chkflt_over, 0);
    chk("rst_state", dbg_state, ST_IDLE);
    drive_edge();
    rstn = 1'b1;
    wait_neg(5);

    // 1: 15-clock glitch on K_1 is filtered out
    drive_edge();
    drv_flt_n[0] = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    drv_flt_n[0] = 1'b1;
    nz = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (fault1 !== 1'b0 || fault !== 1'b0) nz++;
    end
    chk("t1_glitch_ignored", nz, 0);

    // 2: 30-clock fault on K_2 latches 22 clocks after the fall
    drive_edge();
    drv_flt_n[1] = 1'b0;
    wait_neg(22);
    chk("t2_fault2_before", fault2, 0);
    wait_neg(1);
    chk("t2_fault2_set", fault2, 1);
    chk("t2_fault_or", fault, 1);
    repeat (8) @(posedge clk);
    #1;
    drv_flt_n[1] = 1'b0;
    drv_flt_n[1] = 1'b1;
    wait_neg(40);
    chk("t2_fault2_held", fault2, 1);

    // 3: single clear attempt on K_2
    drive_edge();
    chkflt = 1'b1;
    wait_neg(2);
    chk("t3_rst_not_yet", igbt_rst, 0);
    wait_neg(1);
    chk("t3_rst_mask", igbt_rst, 4'b0010);
    n = 0;
    for (int i = 0; i < 600 && igbt_rst === 4'b0010; i++) begin
      n++;
      @(negedge clk);
    end
    chk("t3_pulse_len", n, 500);
    n = 0; nz = 0;
    for (int i = 0; i < 1200 && chkflt_over !== 1'b1; i++) begin
      n++;
      if (igbt_rst !== 4'b0000) nz++;
      @(negedge clk);
    end
    chk("t3_wait_plus_check", n, 1001);
    chk("t3_rst_low_in_wait", nz, 0);
    chk("t3_over", chkflt_over, 1);
    chk("t3_fault2_cleared", fault2, 0);
    chk("t3_fault_cleared", fault, 0);
    wait_neg(1);
    chk("t3_over_one_clk", chkflt_over, 0);

    // 4: K_3 held faulty -> three attempts; a mid-sequence chkflt edge is ignored
    drive_edge();
    chkflt = 1'b0;
    drv_flt_n[2] = 1'b0;
    wait_neg(25);
    chk("t4_fault3_set", fault3, 1);
    drive_edge();
    chkflt = 1'b1;
    run_seq(700, 4'b0100, pulses, minw, maxw, overs, bad);
    chk("t4_pulses", pulses, 3);
    chk("t4_minw", minw, 500);
    chk("t4_maxw", maxw, 500);
    chk("t4_overs", overs, 1);
    chk("t4_bad_mask", bad, 0);
    chk("t4_fault3_kept", fault3, 1);

    // 4b: K_3 recovered -> one attempt clears the latch
    drive_edge();
    chkflt = 1'b0;
    drv_flt_n[2] = 1'b1;
    wait_neg(30);
    chk("t4b_fault3_latched", fault3, 1);
    drive_edge();
    chkflt = 1'b1;
    run_seq(100000, 4'b0100, pulses, minw, maxw, overs, bad);
    chk("t4b_pulses", pulses, 1);
    chk("t4b_overs", overs, 1);
    chk("t4b_bad_mask", bad, 0);
    chk("t4b_fault3_cleared", fault3, 0);
    chk("t4b_fault_cleared", fault, 0);

    // 5: request with no faults
    drive_edge();
    chkflt = 1'b0;
    wait_neg(3);
    drive_edge();
    chkflt = 1'b1;
    wait_neg(2);
    chk("t5_over_early", chkflt_over, 0);
    wait_neg(1);
    chk("t5_over", chkflt_over, 1);
    chk("t5_rst_idle", igbt_rst, 0);
    wait_neg(1);
    chk("t5_over_drop", chkflt_over, 0);
    nz = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (igbt_rst !== 4'b0000 || chkflt_over !== 1'b0) nz++;
    end
    chk("t5_quiet", nz, 0);

    // 6: reset during PULSE with K_4 still faulty
    drive_edge();
    chkflt = 1'b0;
    drv_flt_n[3] = 1'b0;
    wait_neg(25);
    chk("t6_fault4_set", fault4, 1);
    drive_edge();
    chkflt = 1'b1;
    for (int i = 0; i < 10 && igbt_rst !== 4'b1000; i++) @(negedge clk);
    chk("t6_pulse_seen", igbt_rst, 4'b1000);
    wait_neg(100);
    #1;
    rstn = 1'b0;
    chkflt = 1'b0;
    #1;
    chk("t6_rst_drop", igbt_rst, 0);
    chk("t6_fault4_clr", fault4, 0);
    chk("t6_fault_clr", fault, 0);
    chk("t6_state_idle", dbg_state, ST_IDLE);
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    nz = 0;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      if (chkflt_over !== 1'b0 || igbt_rst !== 4'b0000) nz++;
    end
    chk("t6_fault4_before", fault4, 0);
    wait_neg(1);
    chk("t6_fault4_relatch", fault4, 1);
    chk("t6_no_over_no_rst", nz, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
